// File: rtl/rle_encoder_mc.sv
// Back-pressured N-lane run-length encoder with 2-entry output FIFO.
// Define RLE_REPEAT_MODE_EN to honour repeat_mode (inclusive counts).
module rle_encoder_mc #(
   parameter int LANES = 4,
   parameter int MW = 2,
   localparam int DW = 8 * LANES
) (
   input  logic          clock,
   input  logic          reset_n,
   input  logic          enable,
   input  logic [MW-1:0] mode,
   input  logic          repeat_mode,
   input  logic [DW-1:0] data_mask,
   input  logic          flush,
   input  logic          validIn,
   input  logic [DW-1:0] dataIn,
   output logic          readyIn,
   output logic          validOut,
   output logic [DW-1:0] dataOut,
   input  logic          readyOut
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t        state;
   logic [DW-1:0] c_q, l_q, mem0, mem1;
   logic [1:0]    cnt_q;
   logic          en_q, fp_q;
   logic [MW-1:0] cfg_mode;
   logic [DW-1:0] cfg_mask;

   function automatic logic [DW-1:0] f_bit(input logic [MW-1:0] md);
      int s;
      s = (int'(md) > LANES - 1) ? LANES - 1 : int'(md);
      return DW'(1) << (8 * s + 7);
   endfunction

   function automatic logic [DW-1:0] cword(input logic [DW-1:0] fbit,
                                           input logic [DW-1:0] cm,
                                           input logic rep,
                                           input logic [DW-1:0] x);
      return fbit | ((rep ? x + DW'(1) : x) & cm);
   endfunction

   logic          rise, fall, e_rep, accept, pop, fl_req;
   logic [MW-1:0] e_mode;
   logic [DW-1:0] e_mask, fb, cmax, sat, mv, fbp, mp;

   assign rise   = enable & ~en_q;
   assign fall   = ~enable & en_q;
   assign e_mode = rise ? mode : cfg_mode;
   assign e_mask = rise ? data_mask : cfg_mask;

`ifdef RLE_REPEAT_MODE_EN
   logic cfg_rep;
   assign e_rep = rise ? repeat_mode : cfg_rep;
`else
   logic unused_rep;
   assign unused_rep = repeat_mode;
   assign e_rep = 1'b0;
`endif

   assign fb   = f_bit(e_mode);
   assign cmax = fb - DW'(1);
   assign sat  = e_rep ? cmax - DW'(1) : cmax;
   assign mv   = dataIn & e_mask & ((fb << 1) - DW'(1)) & ~fb;
   // pass-through uses the live config and keeps bit F
   assign fbp  = f_bit(mode);
   assign mp   = dataIn & data_mask & ((fbp << 1) - DW'(1));

   assign readyIn  = (cnt_q == 2'd0);
   assign validOut = (cnt_q != 2'd0);
   assign dataOut  = mem0;
   assign accept   = validIn & readyIn;
   assign pop      = validOut & readyOut;
   assign fl_req   = flush | fp_q | fall;

   state_t        st_n;
   logic [DW-1:0] c_n, l_n, cc, cw, vw, t0, t1;
   logic          fp_n, cw_v, vw_v;
   logic [1:0]    n;

   always_comb begin
      st_n = state;
      c_n  = c_q;
      l_n  = l_q;
      fp_n = 1'b0;
      cw_v = 1'b0;
      cw   = '0;
      vw_v = 1'b0;
      vw   = '0;
      cc   = '0;
      if (fl_req) begin
         if (c_q != '0 && cnt_q == 2'd2) begin
            fp_n = 1'b1;
         end else begin
            if (c_q != '0) begin
               cw_v = 1'b1;
               cw   = cword(fb, cmax, e_rep, c_q);
            end
            st_n = IDLE;
            c_n  = '0;
         end
      end
      if (accept) begin
         if (!enable) begin
            vw_v = 1'b1;
            vw   = mp;
            st_n = IDLE;
            c_n  = '0;
         end else if (st_n == IDLE) begin
            vw_v = 1'b1;
            vw   = mv;
            l_n  = mv;
            c_n  = '0;
            st_n = RUN;
         end else if (mv == l_q) begin
            cc = c_q + DW'(1);
            if (cc == sat) begin
               cw_v = 1'b1;
               cw   = cword(fb, cmax, e_rep, cc);
               c_n  = '0;
            end else begin
               c_n = cc;
            end
         end else begin
            if (c_q != '0) begin
               cw_v = 1'b1;
               cw   = cword(fb, cmax, e_rep, c_q);
            end
            vw_v = 1'b1;
            vw   = mv;
            l_n  = mv;
            c_n  = '0;
         end
      end
   end

   // count word always enters the FIFO ahead of the value
   always_comb begin
      t0 = mem0;
      t1 = mem1;
      n  = cnt_q;
      if (pop) begin
         t0 = mem1;
         n  = n - 2'd1;
      end
      if (cw_v) begin
         if (n == 2'd0) t0 = cw;
         else t1 = cw;
         n = n + 2'd1;
      end
      if (vw_v) begin
         if (n == 2'd0) t0 = vw;
         else t1 = vw;
         n = n + 2'd1;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         c_q      <= '0;
         l_q      <= '0;
         mem0     <= '0;
         mem1     <= '0;
         cnt_q    <= 2'd0;
         en_q     <= 1'b0;
         fp_q     <= 1'b0;
         cfg_mode <= '0;
         cfg_mask <= '0;
`ifdef RLE_REPEAT_MODE_EN
         cfg_rep  <= 1'b0;
`endif
      end else begin
         state <= st_n;
         c_q   <= c_n;
         l_q   <= l_n;
         mem0  <= t0;
         mem1  <= t1;
         cnt_q <= n;
         en_q  <= enable;
         fp_q  <= fp_n;
         if (rise) begin
            cfg_mode <= mode;
            cfg_mask <= data_mask;
`ifdef RLE_REPEAT_MODE_EN
            cfg_rep  <= repeat_mode;
`endif
         end
      end
   end

endmodule

// File: tb/tb_rle_encoder_mc.sv
// Scoreboard bench for rle_encoder_mc (LANES=4).
// Expected words queued at stimulus time, compared after draining.
module tb_rle_encoder_mc;

   logic        clock = 1'b0;
   logic        reset_n, enable, repeat_mode, flush, validIn, readyOut;
   logic [1:0]  mode;
   logic [31:0] data_mask, dataIn, dataOut;
   logic        readyIn, validOut;

   int          pass_cnt = 0;
   int          total = 0;
   logic [31:0] exp_q[$];
   logic [31:0] got_q[$];
   logic        rnd_ready = 1'b0;

   always #5 clock = ~clock;

   rle_encoder_mc #(.LANES(4), .MW(2)) dut (
      .clock(clock), .reset_n(reset_n), .enable(enable), .mode(mode),
      .repeat_mode(repeat_mode), .data_mask(data_mask), .flush(flush),
      .validIn(validIn), .dataIn(dataIn), .readyIn(readyIn),
      .validOut(validOut), .dataOut(dataOut), .readyOut(readyOut)
   );

   always @(negedge clock)
      if (reset_n && validOut && readyOut) got_q.push_back(dataOut);

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clock);
      #1;
      if (rnd_ready) readyOut = 1'($urandom_range(0, 1));
   endtask

   task automatic send(input logic [31:0] d);
      int g = 0;
      while (!readyIn && g < 200) begin
         step();
         g++;
      end
      if (g >= 200) begin
         total++;
         $display("FAIL send_timeout readyIn got %b want 1", readyIn);
      end
      validIn = 1'b1;
      dataIn  = d;
      step();
      validIn = 1'b0;
   endtask

   task automatic pulse_flush();
      flush = 1'b1;
      step();
      flush = 1'b0;
   endtask

   task automatic configure(input logic [1:0] md, input logic [31:0] mk,
                            input logic rp);
      enable = 1'b0;
      step();
      step();
      mode = md;
      data_mask = mk;
      repeat_mode = rp;
      enable = 1'b1;
      step();
   endtask

   task automatic drain();
      int g = 0;
      while (validOut && g < 300) begin
         step();
         g++;
      end
      step();
      step();
      total++;
      if (validOut !== 1'b0)
         $display("FAIL drain validOut got %b want 0", validOut);
      else pass_cnt++;
   endtask

   task automatic test_reset();
      total++;
      if (validOut !== 1'b0) $display("FAIL rst_valid got %b want 0", validOut);
      else pass_cnt++;
      total++;
      if (dataOut !== 32'h0) $display("FAIL rst_data got %h want 0", dataOut);
      else pass_cnt++;
      total++;
      if (readyIn !== 1'b1) $display("FAIL rst_ready got %b want 1", readyIn);
      else pass_cnt++;
   endtask

   task automatic test_basic();
      logic [31:0] w, e;
      configure(2'd3, 32'hFFFF_FFFF, 1'b0);
      send(32'h5); exp_q.push_back(32'h0000_0005);
      send(32'h5);
      send(32'h5);
      send(32'h7); exp_q.push_back(32'h8000_0002); exp_q.push_back(32'h0000_0007);
      drain();
      total++;
      if (got_q.size() != exp_q.size())
         $display("FAIL basic_len got %0d want %0d", got_q.size(), exp_q.size());
      else pass_cnt++;
      for (int i = 0; exp_q.size() > 0 && got_q.size() > 0; i++) begin
         w = got_q.pop_front(); e = exp_q.pop_front(); total++;
         if (w !== e) $display("FAIL basic word %0d got %h want %h", i, w, e);
         else pass_cnt++;
      end
      exp_q.delete(); got_q.delete();
   endtask

   task automatic test_repeat();
      logic [31:0] w, e;
      configure(2'd3, 32'hFFFF_FFFF, 1'b1);
      send(32'h5); exp_q.push_back(32'h0000_0005);
      send(32'h5);
      send(32'h5);
      send(32'h7);
`ifdef RLE_REPEAT_MODE_EN
      exp_q.push_back(32'h8000_0003);
`else
      exp_q.push_back(32'h8000_0002);
`endif
      exp_q.push_back(32'h0000_0007);
      drain();
      total++;
      if (got_q.size() != exp_q.size())
         $display("FAIL repeat_len got %0d want %0d", got_q.size(), exp_q.size());
      else pass_cnt++;
      for (int i = 0; exp_q.size() > 0 && got_q.size() > 0; i++) begin
         w = got_q.pop_front(); e = exp_q.pop_front(); total++;
         if (w !== e) $display("FAIL repeat word %0d got %h want %h", i, w, e);
         else pass_cnt++;
      end
      exp_q.delete(); got_q.delete();
   endtask

   task automatic test_saturate();
      logic [31:0] w, e;
      configure(2'd0, 32'hFFFF_FFFF, 1'b0);
      for (int i = 0; i < 130; i++) send(32'h12);
      exp_q.push_back(32'h12);
      exp_q.push_back(32'hFF);
      drain();
      total++;
      if (got_q.size() != 2)
         $display("FAIL sat_preflush got %0d words want 2", got_q.size());
      else pass_cnt++;
      pulse_flush();
      exp_q.push_back(32'h82);
      drain();
      total++;
      if (got_q.size() != exp_q.size())
         $display("FAIL sat_len got %0d want %0d", got_q.size(), exp_q.size());
      else pass_cnt++;
      for (int i = 0; exp_q.size() > 0 && got_q.size() > 0; i++) begin
         w = got_q.pop_front(); e = exp_q.pop_front(); total++;
         if (w !== e) $display("FAIL sat word %0d got %h want %h", i, w, e);
         else pass_cnt++;
      end
      exp_q.delete(); got_q.delete();
   endtask

   task automatic test_mask();
      logic [31:0] w, e;
      configure(2'd3, 32'h0000_000F, 1'b0);
      send(32'h10); exp_q.push_back(32'h0);
      send(32'h20);
      send(32'h31); exp_q.push_back(32'h8000_0001); exp_q.push_back(32'h1);
      drain();
      total++;
      if (got_q.size() != exp_q.size())
         $display("FAIL mask_len got %0d want %0d", got_q.size(), exp_q.size());
      else pass_cnt++;
      for (int i = 0; exp_q.size() > 0 && got_q.size() > 0; i++) begin
         w = got_q.pop_front(); e = exp_q.pop_front(); total++;
         if (w !== e) $display("FAIL mask word %0d got %h want %h", i, w, e);
         else pass_cnt++;
      end
      exp_q.delete(); got_q.delete();
   endtask

   task automatic test_backpressure();
      logic [31:0] w, e;
      logic        stable;
      logic        rdy_low;
      configure(2'd3, 32'hFFFF_FFFF, 1'b0);
      readyOut = 1'b0;
      send(32'hA); exp_q.push_back(32'hA);
      total++;
      if (readyIn !== 1'b0) $display("FAIL bp_ready got %b want 0", readyIn);
      else pass_cnt++;
      stable = 1'b1;
      rdy_low = 1'b1;
      for (int i = 0; i < 10; i++) begin
         validIn = (i == 2);
         dataIn  = 32'hB;
         step();
         if (!(validOut === 1'b1 && dataOut === 32'hA)) stable = 1'b0;
         if (readyIn !== 1'b0) rdy_low = 1'b0;
      end
      validIn = 1'b0;
      total++;
      if (stable !== 1'b1) $display("FAIL bp_stable got %h want %h", dataOut, 32'hA);
      else pass_cnt++;
      total++;
      if (rdy_low !== 1'b1) $display("FAIL bp_hold readyIn got 1 want 0");
      else pass_cnt++;
      readyOut = 1'b1;
      send(32'hB); exp_q.push_back(32'hB);
      send(32'hA); exp_q.push_back(32'hA);
      pulse_flush();
      drain();
      total++;
      if (got_q.size() != exp_q.size())
         $display("FAIL bp_len got %0d want %0d", got_q.size(), exp_q.size());
      else pass_cnt++;
      for (int i = 0; exp_q.size() > 0 && got_q.size() > 0; i++) begin
         w = got_q.pop_front(); e = exp_q.pop_front(); total++;
         if (w !== e) $display("FAIL bp word %0d got %h want %h", i, w, e);
         else pass_cnt++;
      end
      exp_q.delete(); got_q.delete();
   endtask

   task automatic test_back_to_back();
      logic [31:0] w, e, v, ref_v;
      logic        idle;
      int          c;
      idle = 1'b1;
      c = 0;
      ref_v = 32'h0;
      configure(2'd3, 32'hFFFF_FFFF, 1'b0);
      rnd_ready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         v = 32'h11 * (32'($urandom_range(1, 3)));
         send(v);
         if (idle) begin
            exp_q.push_back(v); ref_v = v; c = 0; idle = 1'b0;
         end else if (v == ref_v) begin
            c++;
         end else begin
            if (c > 0) exp_q.push_back(32'h8000_0000 | 32'(c));
            exp_q.push_back(v); ref_v = v; c = 0;
         end
      end
      pulse_flush();
      if (c > 0) exp_q.push_back(32'h8000_0000 | 32'(c));
      rnd_ready = 1'b0;
      readyOut = 1'b1;
      drain();
      total++;
      if (got_q.size() != exp_q.size())
         $display("FAIL b2b_len got %0d want %0d", got_q.size(), exp_q.size());
      else pass_cnt++;
      for (int i = 0; exp_q.size() > 0 && got_q.size() > 0; i++) begin
         w = got_q.pop_front(); e = exp_q.pop_front(); total++;
         if (w !== e) $display("FAIL b2b word %0d got %h want %h", i, w, e);
         else pass_cnt++;
      end
      exp_q.delete(); got_q.delete();
   endtask

   task automatic test_flush_and_sample();
      logic [31:0] w, e;
      configure(2'd3, 32'hFFFF_FFFF, 1'b0);
      send(32'h6); exp_q.push_back(32'h6);
      send(32'h6);
      send(32'h6);
      flush = 1'b1;
      validIn = 1'b1;
      dataIn = 32'h6;
      step();
      flush = 1'b0;
      validIn = 1'b0;
      exp_q.push_back(32'h8000_0002);
      exp_q.push_back(32'h6);
      pulse_flush();
      drain();
      total++;
      if (got_q.size() != exp_q.size())
         $display("FAIL fs_len got %0d want %0d", got_q.size(), exp_q.size());
      else pass_cnt++;
      for (int i = 0; exp_q.size() > 0 && got_q.size() > 0; i++) begin
         w = got_q.pop_front(); e = exp_q.pop_front(); total++;
         if (w !== e) $display("FAIL fs word %0d got %h want %h", i, w, e);
         else pass_cnt++;
      end
      exp_q.delete(); got_q.delete();
   endtask

   task automatic test_passthrough();
      logic [31:0] w, e;
      configure(2'd3, 32'hFFFF_FFFF, 1'b0);
      send(32'h4); exp_q.push_back(32'h4);
      send(32'h4);
      send(32'h4);
      enable = 1'b0;
      validIn = 1'b1;
      dataIn = 32'h8000_0001;
      step();
      validIn = 1'b0;
      exp_q.push_back(32'h8000_0002);
      exp_q.push_back(32'h8000_0001);
      drain();
      total++;
      if (got_q.size() != exp_q.size())
         $display("FAIL pt_len got %0d want %0d", got_q.size(), exp_q.size());
      else pass_cnt++;
      for (int i = 0; exp_q.size() > 0 && got_q.size() > 0; i++) begin
         w = got_q.pop_front(); e = exp_q.pop_front(); total++;
         if (w !== e) $display("FAIL pt word %0d got %h want %h", i, w, e);
         else pass_cnt++;
      end
      exp_q.delete(); got_q.delete();
   endtask

   task automatic test_reset_midrun();
      logic [31:0] w, e;
      configure(2'd3, 32'hFFFF_FFFF, 1'b0);
      for (int i = 0; i < 10; i++) send(32'h9);
      drain();
      got_q.delete();
      reset_n = 1'b0;
      step();
      total++;
      if (validOut !== 1'b0) $display("FAIL mr_valid got %b want 0", validOut);
      else pass_cnt++;
      reset_n = 1'b1;
      step();
      step();
      step();
      total++;
      if (got_q.size() != 0)
         $display("FAIL mr_nocount got %0d words want 0", got_q.size());
      else pass_cnt++;
      send(32'h9); exp_q.push_back(32'h9);
      pulse_flush();
      drain();
      total++;
      if (got_q.size() != exp_q.size())
         $display("FAIL mr_len got %0d want %0d", got_q.size(), exp_q.size());
      else pass_cnt++;
      for (int i = 0; exp_q.size() > 0 && got_q.size() > 0; i++) begin
         w = got_q.pop_front(); e = exp_q.pop_front(); total++;
         if (w !== e) $display("FAIL mr word %0d got %h want %h", i, w, e);
         else pass_cnt++;
      end
      exp_q.delete(); got_q.delete();
   endtask

   initial begin
      reset_n = 1'b0;
      enable = 1'b0;
      mode = 2'd0;
      repeat_mode = 1'b0;
      data_mask = 32'h0;
      flush = 1'b0;
      validIn = 1'b0;
      dataIn = 32'h0;
      readyOut = 1'b1;
      step();
      step();
      test_reset();
      reset_n = 1'b1;
      step();
      test_reset();
      test_basic();
      test_repeat();
      test_saturate();
      test_mask();
      test_backpressure();
      test_back_to_back();
      test_flush_and_sample();
      test_passthrough();
      test_reset_midrun();
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
